eb_fifo_flex: RTL

//  Parametrised elastic-buffer FIFO, successor to the fixed-depth FIFO stage. Sits between a

---
 rtl/eb_fifo_flex.sv | 125 ++++++++++++
 1 files changed

// File: rtl/eb_fifo_flex.sv
// Elastic-buffer FIFO with any-depth circular storage, registered head word, occupancy flags and flush.
// Optional zero-latency bypass of an empty FIFO when EB_FIFO_FALLTHROUGH_EN is defined.
module eb_fifo_flex #(
   parameter int DWIDTH     = 32,
   parameter int DEPTH      = 16,
   parameter int AFULL_THR  = 12,
   parameter int AEMPTY_THR = 2,
   parameter int CWIDTH     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstf,
   input  logic [DWIDTH-1:0] t_data,
   input  logic              t_valid,
   output logic              t_ready,
   output logic [DWIDTH-1:0] i_data,
   output logic              i_valid,
   input  logic              i_ready,
   input  logic              flush,
   output logic [CWIDTH-1:0] count,
   output logic              almost_full,
   output logic              almost_empty
);

   localparam int                PWIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PWIDTH-1:0] PTR_LAST = PWIDTH'(DEPTH - 1);
   localparam logic [CWIDTH-1:0] CNT_FULL = CWIDTH'(DEPTH);

   if (DEPTH < 2 || AFULL_THR < 1 || AFULL_THR > DEPTH ||
       AEMPTY_THR < 0 || AEMPTY_THR >= AFULL_THR) begin : g_param_check
      $fatal(1, "eb_fifo_flex: illegal DEPTH/AFULL_THR/AEMPTY_THR combination");
   end

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CWIDTH-1:0] count_q, count_d;
   logic [DWIDTH-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              write_en, read_en, pass_en;

   // Explicit compare-and-clear wrap so non-power-of-two depths work.
   function automatic logic [PWIDTH-1:0] ptr_inc(input logic [PWIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PWIDTH'(1);
   endfunction

   assign t_ready = rstf && !flush && (count_q < CNT_FULL);

`ifdef EB_FIFO_FALLTHROUGH_EN
   assign pass_en = (count_q == '0) && t_valid && t_ready && i_ready;
   assign i_valid = (count_q == '0) ? (t_valid && rstf && !flush) : out_valid_q;
   assign i_data  = (count_q == '0) ? t_data : out_data_q;
`else
   assign pass_en = 1'b0;
   assign i_valid = out_valid_q;
   assign i_data  = out_data_q;
`endif

   assign write_en = t_valid && t_ready && !pass_en;
   assign read_en  = out_valid_q && i_ready && !flush;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (write_en) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (read_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({write_en, read_en})
            2'b10:   count_d = count_q + CWIDTH'(1);
            2'b01:   count_d = count_q - CWIDTH'(1);
            default: count_d = count_q;
         endcase
         // Head register mirrors mem_q[rd_ptr]; bypass t_data when the new head is written this edge.
         if (read_en) begin
            if (count_q > CWIDTH'(1)) begin
               out_data_d  = mem_q[rd_ptr_d];
               out_valid_d = 1'b1;
            end else if (write_en) begin
               out_data_d  = t_data;
               out_valid_d = 1'b1;
            end else begin
               out_valid_d = 1'b0;
            end
         end else if (write_en && !out_valid_q) begin
            out_data_d  = t_data;
            out_valid_d = 1'b1;
         end
      end
   end

   // NOTE: storage array has no reset; count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (write_en) mem_q[wr_ptr_q] <= t_data;
   end

   always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign count        = count_q;
   assign almost_full  = (count_q >= CWIDTH'(AFULL_THR));
   assign almost_empty = (count_q <= CWIDTH'(AEMPTY_THR));

endmodule
